ins_enc: RTL and testbench
==========================

# ins_enc

Instruction encoder for the NPC RV32I core: the inverse of instruction decode. It accepts decoded fields on a valid/ready input: format class, register ids, immediate, EXU op and LSU op. It packs them into the 32-bit RV32I encoding and queues the result in a small FIFO for a downstream consumer (instruction injection, trace regeneration, decode round-trip checking). Unencodable requests are rejected with an error pulse and never enter the queue.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2.
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  reset: synchronous, active-low.
- i_valid  in  1  request valid.
- o_ready  out  1  request can be accepted (FIFO not full).
- i_fmt  in  4  format: 0 R, 1 I, 2 LOAD, 3 JALR, 4 S, 5 B, 6 LUI, 7 AUIPC, 8 J, 9 EBRK; 10–15 illegal.
- i_rdid / i_rs1id / i_rs2id  in  `REG_ADDRW each  register ids.
- i_imm  in  `CPU_WIDTH  immediate, already sign-extended/shifted as the decoder presents it.
- i_exu_opt  in  `EXU_OPT_WIDTH  ALU/branch op (R, I, B only).
- i_lsu_opt  in  `LSU_OPT_WIDTH  {func3, store} (LOAD, S only).
- o_valid  out  1  FIFO head valid.
- i_ready  in  1  consumer takes head.
- o_ins  out  32  encoded instruction at head.
- o_err  out  1  one-cycle pulse: last accepted request rejected.
- o_level  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Accept = i_valid & o_ready. Encoding is combinational from inputs; the result is written to the tail on the accept edge unless rejected.
- R: func7/func3 from exu_opt: ADD 0000000/000, SUB 0100000/000, SLL /001, SLT /010, SLTU /011, XOR /100, SRL 0000000/101, SRA 0100000/101, OR /110, AND /111; opcode 0110011.
- I (0010011): same func3; imm[11:0] in [31:20]. SLL/SRL/SRA place func7 in [31:25] and imm[4:0] in [24:20]. SUB and branch ops are errors.
- LOAD (0000011) / S (0100011): func3 = lsu_opt[3:1]. lsu_opt[0] must be 0 for LOAD and 1 for S, else error. Loads with func3 ∈ {3,6,7} and stores with func3 > 2 are errors.
- JALR 1100111 func3 000. LUI 0110111 / AUIPC 0010111: imm[31:12]. J 1101111: imm[20|10:1|11|19:12]. B 1100011: func3 BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111; non-branch exu_opt is an error. EBRK: fixed 0x00100073, fields ignored.
- Illegal i_fmt → error. Fields unused by a format are ignored (not encoded).
- Rejected request: consumes the handshake, o_err=1 next cycle, FIFO unchanged.
- FIFO: head pops when o_valid & i_ready. No bypass: a push into an empty FIFO is visible the cycle after. o_ready = (o_level != DEPTH) from registered state. A pop in the same cycle as a full FIFO does not enable a push.

## Timing
- Reset values: o_valid 0, o_ready 1 (after reset cycle), o_ins 0, o_err 0, o_level 0; pointers cleared. Reset mid-operation discards all queued entries and any pending o_err.
- Latency: accept at edge N → o_valid, o_ins at N+1. Throughput: 1/cycle while not full.
- Simultaneous push and pop (not full): o_level unchanged, order preserved. Pointers wrap modulo DEPTH.
- o_ins is stable while o_valid & !i_ready.

## Configuration
- ENC_IMM_CHK_EN defined: range checks also reject requests.
  - I/LOAD/JALR/S: imm must be the sign-extension of 12 bits.
  - Shifts: imm[31:5]=0.
  - B: 13-bit signed and imm[0]=0.
  - J: 21-bit signed and imm[0]=0.
  - LUI/AUIPC: imm[11:0]=0.
- Undefined: immediates silently truncated to the encodable bits. Only fmt/opt/lsu errors are flagged.

## Test plan
- R ADD rd=1 rs1=2 rs2=3 → o_ins 0x003100B3 one cycle after accept. R SRA rd=3 rs1=1 rs2=2 → 0x4020D1B3.
- I ADD rd=5 rs1=0 imm=0xFFFFFFFF → 0xFFF00293. LUI rd=1 imm=0x12345000 → 0x123450B7. EBRK → 0x00100073.
- B BEQ imm=3 with ENC_IMM_CHK_EN → o_err pulse, o_level stays 0. Without the macro → enqueued with imm[0] dropped. I SUB → o_err regardless.
- DEPTH=4, i_ready=0, 6 back-to-back requests → 4 accepted, o_ready=0 after 4th, o_level=4. Then i_ready=1 → drained in order, one per cycle.
- Continuous push+pop at level 2 → level constant, outputs in order across pointer wrap.
- Reset asserted with level 3 → next cycle o_valid=0, o_level=0, o_err=0.

Source files
------------

// File: rtl/ins_enc_if.sv
`default_nettype none
// ============================================================================
// Module      : ins_enc_if
// Description : Request / queue bundle for the ins_enc instruction encoder.
//               Also provides the field widths and EXU op codes shared with
//               the decode side when they are not already defined.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef EXU_OPT_WIDTH
`define EXU_OPT_WIDTH 5
`endif
`ifndef LSU_OPT_WIDTH
`define LSU_OPT_WIDTH 4
`endif

// EXU op codes (5-bit); anything not listed is not an ALU or branch op
`ifndef EXU_ADD
`define EXU_ADD  5'd0
`define EXU_SUB  5'd1
`define EXU_SLL  5'd2
`define EXU_SLT  5'd3
`define EXU_SLTU 5'd4
`define EXU_XOR  5'd5
`define EXU_SRL  5'd6
`define EXU_SRA  5'd7
`define EXU_OR   5'd8
`define EXU_AND  5'd9
`define EXU_BEQ  5'd10
`define EXU_BNE  5'd11
`define EXU_BLT  5'd12
`define EXU_BGE  5'd13
`define EXU_BLTU 5'd14
`define EXU_BGEU 5'd15
`endif

interface ins_enc_if #(
  parameter int DEPTH = 4
) ();
  // request side
  logic                      i_valid;
  logic                      o_ready;
  logic [3:0]                i_fmt;
  logic [`REG_ADDRW-1:0]     i_rdid;
  logic [`REG_ADDRW-1:0]     i_rs1id;
  logic [`REG_ADDRW-1:0]     i_rs2id;
  logic [`CPU_WIDTH-1:0]     i_imm;
  logic [`EXU_OPT_WIDTH-1:0] i_exu_opt;
  logic [`LSU_OPT_WIDTH-1:0] i_lsu_opt;
  // queue side
  logic                      o_valid;
  logic                      i_ready;
  logic [31:0]               o_ins;
  logic                      o_err;
  logic [$clog2(DEPTH):0]    o_level;

  modport master (
    output i_valid, i_fmt, i_rdid, i_rs1id, i_rs2id, i_imm, i_exu_opt, i_lsu_opt, i_ready,
    input  o_ready, o_valid, o_ins, o_err, o_level
  );

  modport slave (
    input  i_valid, i_fmt, i_rdid, i_rs1id, i_rs2id, i_imm, i_exu_opt, i_lsu_opt, i_ready,
    output o_ready, o_valid, o_ins, o_err, o_level
  );
endinterface

`default_nettype wire

// File: rtl/ins_enc.sv
`default_nettype none
// ============================================================================
// Module      : ins_enc
// Description : RV32I instruction encoder. Packs decoded fields into the
//               32-bit encoding and queues them in a DEPTH-entry FIFO.
//               Unencodable requests pulse o_err and are dropped.
//               Optional macro ENC_IMM_CHK_EN: also reject immediates that
//               do not fit the format's encodable range.
// Revision    : 1.0 - initial release
// ============================================================================

module ins_enc #(
  parameter int DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  ins_enc_if.slave bus
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [3:0] FMT_R     = 4'd0;
  localparam logic [3:0] FMT_I     = 4'd1;
  localparam logic [3:0] FMT_LOAD  = 4'd2;
  localparam logic [3:0] FMT_JALR  = 4'd3;
  localparam logic [3:0] FMT_S     = 4'd4;
  localparam logic [3:0] FMT_B     = 4'd5;
  localparam logic [3:0] FMT_LUI   = 4'd6;
  localparam logic [3:0] FMT_AUIPC = 4'd7;
  localparam logic [3:0] FMT_J     = 4'd8;
  localparam logic [3:0] FMT_EBRK  = 4'd9;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_J     = 7'b1101111;
  localparam logic [31:0] INS_EBRK = 32'h0010_0073;

  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic [2:0]  mem_f3;
  logic        mem_st;

  assign rd     = bus.i_rdid;
  assign rs1    = bus.i_rs1id;
  assign rs2    = bus.i_rs2id;
  assign imm    = bus.i_imm;
  assign mem_f3 = bus.i_lsu_opt[3:1];
  assign mem_st = bus.i_lsu_opt[0];

`ifdef ENC_IMM_CHK_EN
  logic fits12;
  logic fits13;
  logic fits21;
  assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);
`endif

  logic       alu_op;
  logic       sub_op;
  logic       shift_op;
  logic       br_op;
  logic [2:0] alu_f3;
  logic [6:0] alu_f7;
  logic [2:0] br_f3;

  // Classify the EXU op and derive its func3/func7
  always_comb begin
    alu_op   = 1'b1;
    sub_op   = 1'b0;
    shift_op = 1'b0;
    br_op    = 1'b0;
    alu_f3   = 3'b000;
    alu_f7   = 7'b0000000;
    br_f3    = 3'b000;
    case (bus.i_exu_opt)
      `EXU_ADD:  alu_f3 = 3'b000;
      `EXU_SUB:  begin alu_f3 = 3'b000; alu_f7 = 7'b0100000; sub_op = 1'b1; end
      `EXU_SLL:  begin alu_f3 = 3'b001; shift_op = 1'b1; end
      `EXU_SLT:  alu_f3 = 3'b010;
      `EXU_SLTU: alu_f3 = 3'b011;
      `EXU_XOR:  alu_f3 = 3'b100;
      `EXU_SRL:  begin alu_f3 = 3'b101; shift_op = 1'b1; end
      `EXU_SRA:  begin alu_f3 = 3'b101; alu_f7 = 7'b0100000; shift_op = 1'b1; end
      `EXU_OR:   alu_f3 = 3'b110;
      `EXU_AND:  alu_f3 = 3'b111;
      `EXU_BEQ:  begin alu_op = 1'b0; br_op = 1'b1; br_f3 = 3'b000; end
      `EXU_BNE:  begin alu_op = 1'b0; br_op = 1'b1; br_f3 = 3'b001; end
      `EXU_BLT:  begin alu_op = 1'b0; br_op = 1'b1; br_f3 = 3'b100; end
      `EXU_BGE:  begin alu_op = 1'b0; br_op = 1'b1; br_f3 = 3'b101; end
      `EXU_BLTU: begin alu_op = 1'b0; br_op = 1'b1; br_f3 = 3'b110; end
      `EXU_BGEU: begin alu_op = 1'b0; br_op = 1'b1; br_f3 = 3'b111; end
      default:   alu_op = 1'b0;
    endcase
  end

  logic [31:0] enc;
  logic        bad;

  // Pack the fields for the requested format and flag unencodable requests
  always_comb begin
    enc = 32'h0;
    bad = 1'b0;
    case (bus.i_fmt)
      FMT_R: begin
        enc = {alu_f7, rs2, rs1, alu_f3, rd, OPC_R};
        bad = !alu_op;
      end
      FMT_I: begin
        if (shift_op) begin
          enc = {alu_f7, imm[4:0], rs1, alu_f3, rd, OPC_I};
`ifdef ENC_IMM_CHK_EN
          if (imm[31:5] != '0) bad = 1'b1;
`endif
        end else begin
          enc = {imm[11:0], rs1, alu_f3, rd, OPC_I};
`ifdef ENC_IMM_CHK_EN
          if (!fits12) bad = 1'b1;
`endif
        end
        if (!alu_op || sub_op) bad = 1'b1;
      end
      FMT_LOAD: begin
        enc = {imm[11:0], rs1, mem_f3, rd, OPC_LOAD};
        // LD, LWU and the reserved func3 do not exist in RV32I
        if (mem_st || mem_f3 == 3'd3 || mem_f3 == 3'd6 || mem_f3 == 3'd7) bad = 1'b1;
`ifdef ENC_IMM_CHK_EN
        if (!fits12) bad = 1'b1;
`endif
      end
      FMT_JALR: begin
        enc = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
`ifdef ENC_IMM_CHK_EN
        if (!fits12) bad = 1'b1;
`endif
      end
      FMT_S: begin
        enc = {imm[11:5], rs2, rs1, mem_f3, imm[4:0], OPC_S};
        if (!mem_st || mem_f3 > 3'd2) bad = 1'b1;
`ifdef ENC_IMM_CHK_EN
        if (!fits12) bad = 1'b1;
`endif
      end
      FMT_B: begin
        enc = {imm[12], imm[10:5], rs2, rs1, br_f3, imm[4:1], imm[11], OPC_B};
        if (!br_op) bad = 1'b1;
`ifdef ENC_IMM_CHK_EN
        if (!fits13 || imm[0]) bad = 1'b1;
`endif
      end
      FMT_LUI, FMT_AUIPC: begin
        enc = {imm[31:12], rd, (bus.i_fmt == FMT_LUI) ? OPC_LUI : OPC_AUIPC};
`ifdef ENC_IMM_CHK_EN
        if (imm[11:0] != '0) bad = 1'b1;
`endif
      end
      FMT_J: begin
        enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_J};
`ifdef ENC_IMM_CHK_EN
        if (!fits21 || imm[0]) bad = 1'b1;
`endif
      end
      FMT_EBRK: enc = INS_EBRK;
      default:  bad = 1'b1;
    endcase
  end

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          err;
  logic          accept;
  logic          push;
  logic          pop;

  // A rejected request still consumes the handshake but never reaches the queue
  assign accept      = bus.i_valid & bus.o_ready;
  assign push        = accept & ~bad;
  assign pop         = bus.o_valid & bus.i_ready;
  assign bus.o_ready = (level != LEVEL_FULL);
  assign bus.o_valid = (level != '0);
  assign bus.o_ins   = bus.o_valid ? mem[rd_ptr] : 32'h0;
  assign bus.o_err   = err;
  assign bus.o_level = level;

  // Queue pointers, occupancy and the reject pulse
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      err    <= 1'b0;
    end else begin
      err <= accept & bad;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents are don't-care until the pointers cover them
  always_ff @(posedge i_clk) begin
    if (i_rst_n && push) mem[wr_ptr] <= enc;
  end

endmodule

`default_nettype wire

// File: tb/tb_ins_enc.sv
`default_nettype none
// ============================================================================
// Module      : tb_ins_enc
// Description : Self-checking bench for ins_enc with a queue-based reference
//               model. Honors ENC_IMM_CHK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_ins_enc;

  localparam int DEPTH = 4;

`ifdef ENC_IMM_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] q[$];
  bit          exp_err;

  int alu_f3_tab [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int br_f3_tab  [6]  = '{0, 1, 4, 5, 6, 7};

  ins_enc_if #(.DEPTH(DEPTH)) bus ();

  ins_enc #(.DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder: field placement written as shifts and masks
  function automatic void model_encode(input int fmt, input int rd, input int rs1, input int rs2,
                                       input logic [31:0] imm, input int op, input int lsu,
                                       output logic [31:0] ins, output bit err);
    logic [31:0] d, r1, r2, f3;
    int si;
    d   = 32'(rd) << 7;
    r1  = 32'(rs1) << 15;
    r2  = 32'(rs2) << 20;
    si  = int'($signed(imm));
    ins = 32'h0;
    err = 1'b0;
    f3  = 32'(lsu >> 1);
    case (fmt)
      0: begin
        if (op > 9) err = 1'b1;
        else ins = (((op == 1 || op == 7) ? 32'd32 : 32'd0) << 25) | r2 | r1 |
                   (32'(alu_f3_tab[op]) << 12) | d | 32'h33;
      end
      1: begin
        if (op > 9 || op == 1) err = 1'b1;
        else if (op == 2 || op == 6 || op == 7) begin
          ins = ((op == 7 ? 32'd32 : 32'd0) << 25) | ((imm & 32'h1f) << 20) | r1 |
                (32'(alu_f3_tab[op]) << 12) | d | 32'h13;
          if (CHK && (imm >> 5) != 0) err = 1'b1;
        end else begin
          ins = ((imm & 32'hfff) << 20) | r1 | (32'(alu_f3_tab[op]) << 12) | d | 32'h13;
          if (CHK && (si < -2048 || si > 2047)) err = 1'b1;
        end
      end
      2: begin
        ins = ((imm & 32'hfff) << 20) | r1 | (f3 << 12) | d | 32'h03;
        if ((lsu % 2) == 1 || f3 == 3 || f3 == 6 || f3 == 7) err = 1'b1;
        if (CHK && (si < -2048 || si > 2047)) err = 1'b1;
      end
      3: begin
        ins = ((imm & 32'hfff) << 20) | r1 | d | 32'h67;
        if (CHK && (si < -2048 || si > 2047)) err = 1'b1;
      end
      4: begin
        ins = (((imm >> 5) & 32'h7f) << 25) | r2 | r1 | (f3 << 12) | ((imm & 32'h1f) << 7) | 32'h23;
        if ((lsu % 2) == 0 || f3 > 2) err = 1'b1;
        if (CHK && (si < -2048 || si > 2047)) err = 1'b1;
      end
      5: begin
        if (op < 10 || op > 15) err = 1'b1;
        else ins = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | r2 | r1 |
                   (32'(br_f3_tab[op-10]) << 12) | (((imm >> 1) & 32'hf) << 8) |
                   (((imm >> 11) & 1) << 7) | 32'h63;
        if (CHK && (si < -4096 || si > 4095 || imm[0])) err = 1'b1;
      end
      6, 7: begin
        ins = (imm & 32'hfffff000) | d | (fmt == 6 ? 32'h37 : 32'h17);
        if (CHK && (imm & 32'hfff) != 0) err = 1'b1;
      end
      8: begin
        ins = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21) |
              (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12) | d | 32'h6f;
        if (CHK && (si < -1048576 || si > 1048575 || imm[0])) err = 1'b1;
      end
      9: ins = 32'h0010_0073;
      default: err = 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one clock and update the reference queue from the inputs in force
  task automatic clock_model();
    bit acc, rej, pop;
    logic [31:0] ins;
    acc = bus.i_valid && (q.size() < DEPTH);
    pop = (q.size() > 0) && bus.i_ready;
    model_encode(int'(bus.i_fmt), int'(bus.i_rdid), int'(bus.i_rs1id), int'(bus.i_rs2id),
                 bus.i_imm, int'(bus.i_exu_opt), int'(bus.i_lsu_opt), ins, rej);
    tick();
    if (pop) void'(q.pop_front());
    if (acc && !rej) q.push_back(ins);
    exp_err = acc && rej;
  endtask

  task automatic set_req(input int fmt, input int rd, input int rs1, input int rs2,
                         input logic [31:0] imm, input int op, input int lsu);
    bus.i_valid   = 1'b1;
    bus.i_fmt     = 4'(fmt);
    bus.i_rdid    = 5'(rd);
    bus.i_rs1id   = 5'(rs1);
    bus.i_rs2id   = 5'(rs2);
    bus.i_imm     = imm;
    bus.i_exu_opt = 5'(op);
    bus.i_lsu_opt = 4'(lsu);
  endtask

  task automatic rand_req();
    int fmt;
    logic [31:0] imm;
    fmt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
    case ($urandom_range(0, 4))
      0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1:       imm = 32'($urandom_range(0, 31));
      2:       imm = $urandom() & 32'hFFFFF000;
      3:       imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      default: imm = $urandom();
    endcase
    set_req(fmt, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            imm, int'($urandom_range(0, 19)), int'($urandom_range(0, 15)));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    q.delete();
    exp_err = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
    checks++; if (bus.o_ins !== 32'h0) begin errors++; $display("FAIL reset_ins: got %h want 0", bus.o_ins); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.o_err); end
    checks++; if (bus.o_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.o_level); end
  endtask

  task automatic run_directed(input string name, input int fmt, input int rd, input int rs1, input int rs2,
                              input logic [31:0] imm, input int op, input int lsu, input logic [31:0] exp);
    set_req(fmt, rd, rs1, rs2, imm, op, lsu);
    clock_model();
    bus.i_valid = 1'b0;
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, bus.o_valid); end
    checks++; if (bus.o_ins !== exp) begin errors++; $display("FAIL %s_ins: got %h want %h", name, bus.o_ins, exp); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL %s_err: got %b want 0", name, bus.o_err); end
    bus.i_ready = 1'b1;
    clock_model();
    bus.i_ready = 1'b0;
    checks++; if (bus.o_level !== 3'd0) begin errors++; $display("FAIL %s_drain: got %0d want 0", name, bus.o_level); end
  endtask

  task automatic test_directed();
    run_directed("r_add",  0, 1, 2, 3, 32'h0,        `EXU_ADD, 0, 32'h003100B3);
    run_directed("r_sra",  0, 3, 1, 2, 32'h0,        `EXU_SRA, 0, 32'h4020D1B3);
    run_directed("i_add",  1, 5, 0, 0, 32'hFFFFFFFF, `EXU_ADD, 0, 32'hFFF00293);
    run_directed("lui",    6, 1, 0, 0, 32'h12345000, `EXU_ADD, 0, 32'h123450B7);
    run_directed("ebrk",   9, 7, 8, 9, 32'h5A5A5A5A, `EXU_SUB, 3, 32'h00100073);
    run_directed("lw",     2, 6, 7, 0, 32'd8,        `EXU_ADD, 4, 32'h0083A303);
    run_directed("sw",     4, 0, 2, 5, 32'd12,       `EXU_ADD, 5, 32'h00512623);
  endtask

  task automatic expect_reject(input string name);
    clock_model();
    bus.i_valid = 1'b0;
    checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL %s_err: got %b want 1", name, bus.o_err); end
    checks++; if (bus.o_level !== 3'd0) begin errors++; $display("FAIL %s_level: got %0d want 0", name, bus.o_level); end
    clock_model();
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL %s_pulse: got %b want 0", name, bus.o_err); end
  endtask

  task automatic test_errors();
    set_req(1, 1, 2, 0, 32'd5, `EXU_SUB, 0);
    expect_reject("i_sub");
    set_req(12, 1, 2, 3, 32'd0, `EXU_ADD, 0);
    expect_reject("bad_fmt");
    set_req(2, 1, 2, 0, 32'd0, `EXU_ADD, 5);
    expect_reject("load_st_bit");
    set_req(5, 0, 1, 2, 32'd3, `EXU_BEQ, 0);
`ifdef ENC_IMM_CHK_EN
    expect_reject("beq_odd");
`else
    clock_model();
    bus.i_valid = 1'b0;
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL beq_trunc_err: got %b want 0", bus.o_err); end
    checks++; if (bus.o_ins !== 32'h00208163) begin errors++; $display("FAIL beq_trunc_ins: got %h want 00208163", bus.o_ins); end
    bus.i_ready = 1'b1;
    clock_model();
    bus.i_ready = 1'b0;
`endif
  endtask

  task automatic test_fill_drain();
    bus.i_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_req(0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              32'h0, int'($urandom_range(0, 9)), 0);
      clock_model();
      checks++;
      if (bus.o_ready !== (k < 3)) begin errors++; $display("FAIL fill_ready%0d: got %b want %b", k, bus.o_ready, k < 3); end
    end
    bus.i_valid = 1'b0;
    checks++; if (bus.o_level !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d want 4", bus.o_level); end
    bus.i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.o_ins !== q[0]) begin errors++; $display("FAIL drain_ins%0d: got %h want %h", k, bus.o_ins, q[0]); end
      clock_model();
      checks++; if (bus.o_level !== 3'(3 - k)) begin errors++; $display("FAIL drain_level%0d: got %0d want %0d", k, bus.o_level, 3 - k); end
    end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", bus.o_valid); end
    bus.i_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_req(8, int'($urandom_range(0, 31)), 0, 0, $urandom() & ~32'd1, 0, 0);
      clock_model();
    end
    bus.i_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      set_req(0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              32'h0, int'($urandom_range(0, 9)), 0);
      checks++; if (bus.o_level !== 3'd2) begin errors++; $display("FAIL b2b_level%0d: got %0d want 2", k, bus.o_level); end
      checks++; if (bus.o_ins !== q[0]) begin errors++; $display("FAIL b2b_ins%0d: got %h want %h", k, bus.o_ins, q[0]); end
      clock_model();
    end
    bus.i_valid = 1'b0;
    for (int k = 0; k < 3; k++) clock_model();
    bus.i_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 7) rand_req();
      else bus.i_valid = 1'b0;
      bus.i_ready = ($urandom_range(0, 2) != 0);
      checks++; if (bus.o_level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level%0d: got %0d want %0d", k, bus.o_level, q.size()); end
      checks++; if (bus.o_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid%0d: got %b", k, bus.o_valid); end
      checks++; if (bus.o_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready%0d: got %b", k, bus.o_ready); end
      checks++; if (bus.o_err !== exp_err) begin errors++; $display("FAIL rnd_err%0d: got %b want %b", k, bus.o_err, exp_err); end
      if (q.size() != 0) begin
        checks++; if (bus.o_ins !== q[0]) begin errors++; $display("FAIL rnd_ins%0d: got %h want %h", k, bus.o_ins, q[0]); end
      end
      clock_model();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    for (int k = 0; k < 6; k++) clock_model();
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(9, 0, 0, 0, 32'h0, 0, 0);
      clock_model();
    end
    checks++; if (bus.o_level !== 3'd3) begin errors++; $display("FAIL rmid_pre: got %0d want 3", bus.o_level); end
    set_req(13, 0, 0, 0, 32'h0, 0, 0);
    rst_n = 1'b0;
    tick();
    q.delete();
    exp_err = 1'b0;
    bus.i_valid = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_level !== 3'd0) begin errors++; $display("FAIL rmid_level: got %0d want 0", bus.o_level); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", bus.o_err); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", bus.o_ready); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    exp_err       = 1'b0;
    rst_n         = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_ready   = 1'b0;
    bus.i_fmt     = '0;
    bus.i_rdid    = '0;
    bus.i_rs1id   = '0;
    bus.i_rs2id   = '0;
    bus.i_imm     = '0;
    bus.i_exu_opt = '0;
    bus.i_lsu_opt = '0;
    test_reset();
    test_directed();
    test_errors();
    test_fill_drain();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
